// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor
//   XORs a stream of 128-bit words with a ChaCha keystream delivered as
//   512-bit blocks. Each keystream block covers four words (lane 0 = bits
//   127:0). One-cycle latency from din accept to dout_valid.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a message (honoured only in IDLE)
//   din_*             input word stream (valid/ready, data, last)
//   dout_*            output word stream (valid/ready, data, last)
//   ks_req            one-cycle keystream block request
//   ks_valid, ks_data keystream block response
//   busy              state != IDLE or output word still pending
//
// Build option
//   CHACHA_XOR_PREFETCH_EN : adds a second keystream buffer (nxt_buf) that is
//   requested one cycle after each ks_buf load, so block boundaries can be
//   crossed without a bubble.
module chacha_stream_xor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [127:0] din_data,
  input  logic         din_last,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [127:0] dout_data,
  output logic         dout_last,
  output logic         ks_req,
  input  logic         ks_valid,
  input  logic [511:0] ks_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_KS, XOR} state_t;

  state_t       state, state_nxt;
  logic [511:0] ks_buf;
  logic [511:0] ks_load_data;
  logic [1:0]   lane;
  logic [127:0] ks_lane;
  logic         accept;
  logic         ks_load;

`ifdef CHACHA_XOR_PREFETCH_EN
  logic [511:0] nxt_buf;
  logic         nxt_vld;
  logic         nxt_load;
  logic         nxt_use;
  logic         pf_req;
  logic         pend;
  logic         drop;
  logic         take_ks;
`endif

  always_comb begin
    din_ready    = (state == XOR) && (!dout_valid || dout_ready);
    accept       = din_valid && din_ready;
    ks_lane      = ks_buf[{lane, 7'd0} +: 128];
    busy         = (state != IDLE) || dout_valid;
    state_nxt    = state;
    ks_load      = 1'b0;
    ks_load_data = ks_data;
`ifdef CHACHA_XOR_PREFETCH_EN
    ks_req   = (state == REQ) || pf_req;
    // A response owed to an abandoned message is swallowed via drop.
    take_ks  = ks_valid && !drop;
    nxt_load = 1'b0;
    nxt_use  = 1'b0;
`else
    ks_req   = (state == REQ);
`endif

    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ:  state_nxt = WAIT_KS;
      WAIT_KS: begin
`ifdef CHACHA_XOR_PREFETCH_EN
        if (take_ks) begin
`else
        if (ks_valid) begin
`endif
          ks_load   = 1'b1;
          state_nxt = XOR;
        end
      end
      XOR: begin
        if (accept && din_last) begin
          state_nxt = IDLE;
        end else if (accept && lane == 2'd3) begin
`ifdef CHACHA_XOR_PREFETCH_EN
          // Roll into the prefetched block; a response landing in this very
          // cycle can be used directly instead of parking it in nxt_buf.
          if (nxt_vld) begin
            ks_load      = 1'b1;
            ks_load_data = nxt_buf;
            nxt_use      = 1'b1;
          end else if (take_ks) begin
            ks_load = 1'b1;
          end else begin
            state_nxt = WAIT_KS;
          end
`else
          state_nxt = REQ;
`endif
        end
`ifdef CHACHA_XOR_PREFETCH_EN
        else if (take_ks) begin
          nxt_load = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= '0;
      ks_buf     <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ks_load) ks_buf <= ks_load_data;
      if (accept) lane <= din_last ? 2'd0 : lane + 2'd1;
      else if (ks_load) lane <= '0;
      if (accept) begin
        dout_data  <= din_data ^ ks_lane;
        dout_last  <= din_last;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef CHACHA_XOR_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_buf <= '0;
      nxt_vld <= 1'b0;
      pf_req  <= 1'b0;
      pend    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      pf_req <= ks_load;
      if (ks_req) pend <= 1'b1;
      else if (take_ks) pend <= 1'b0;
      if (ks_valid && drop) drop <= 1'b0;
      else if (accept && din_last && (pend || ks_req) && !take_ks) drop <= 1'b1;
      if (accept && din_last) begin
        nxt_vld <= 1'b0;
      end else if (nxt_load) begin
        nxt_buf <= ks_data;
        nxt_vld <= 1'b1;
      end else if (nxt_use) begin
        nxt_vld <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_chacha_stream_xor.sv
module tb_chacha_stream_xor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [127:0] din_data = '0;
  logic         din_last = 1'b0;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic [127:0] dout_data;
  logic         dout_last;
  logic         ks_req;
  logic         ks_valid = 1'b0;
  logic [511:0] ks_data = '0;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int ks_req_cnt = 0;
  int xfer_cnt = 0;

  localparam logic [511:0] KS1 = {{32{4'h3}}, {32{4'h2}}, {32{4'h1}}, {32{4'h0}}};
  localparam logic [511:0] KS2 = {{32{4'hF}}, {32{4'hE}}, {32{4'hD}}, {32{4'hC}}};

  chacha_stream_xor dut (
    .clk(clk), .rst(rst), .start(start),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_last(din_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
    .ks_req(ks_req), .ks_valid(ks_valid), .ks_data(ks_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ks_req) ks_req_cnt++;
  always @(posedge clk) if (!rst && dout_valid && dout_ready) xfer_cnt++;

  function automatic logic [127:0] lane_pat(input logic [3:0] n);
    return {32{n}};
  endfunction

  function automatic logic [127:0] word(input int i);
    logic [7:0] b;
    b = 8'(i * 17 + 5);
    return {16{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_msg(input logic [511:0] ks);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ks_valid = 1'b1;
    ks_data  = ks;
    tick();
    ks_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b want 0", din_ready); end
    checks++;
    if (ks_req !== 1'b0) begin errors++; $display("FAIL reset_ks_req: got %b want 0", ks_req); end
    checks++;
    if (dout_data !== 128'h0) begin errors++; $display("FAIL reset_dout_data: got %h want 0", dout_data); end
  endtask

  task automatic test_basic();
    int c0;
    c0 = ks_req_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (ks_req !== 1'b1) begin errors++; $display("FAIL basic_ks_req_hi: got %b want 1", ks_req); end
    tick();
    checks++;
    if (ks_req !== 1'b0 || din_ready !== 1'b0) begin
      errors++; $display("FAIL basic_wait: ks_req=%b din_ready=%b want 0 0", ks_req, din_ready);
    end
    ks_valid = 1'b1;
    ks_data  = KS1;
    tick();
    ks_valid   = 1'b0;
    dout_ready = 1'b1;
    din_valid  = 1'b1;
    din_data   = '0;
    for (int i = 0; i < 4; i++) begin
      din_last = (i == 3);
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_data !== lane_pat(4'(i))) begin
        errors++;
        $display("FAIL basic_word%0d: got v=%b %h want v=1 %h", i, dout_valid, dout_data, lane_pat(4'(i)));
      end
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
`ifndef CHACHA_XOR_PREFETCH_EN
    checks++;
    if (ks_req_cnt - c0 !== 1) begin errors++; $display("FAIL basic_ks_req_count: got %0d want 1", ks_req_cnt - c0); end
`endif
  endtask

`ifndef CHACHA_XOR_PREFETCH_EN
  task automatic test_six_words();
    begin_msg(KS1);
    dout_ready = 1'b1;
    din_valid  = 1'b1;
    din_last   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_data = word(i);
      tick();
      checks++;
      if (dout_data !== (word(i) ^ lane_pat(4'(i))) || dout_last !== 1'b0) begin
        errors++;
        $display("FAIL six_word%0d: got %h last=%b want %h last=0", i, dout_data, dout_last, word(i) ^ lane_pat(4'(i)));
      end
    end
    checks++;
    if (ks_req !== 1'b1 || din_ready !== 1'b0) begin
      errors++; $display("FAIL six_second_req: ks_req=%b din_ready=%b want 1 0", ks_req, din_ready);
    end
    din_data = word(4);
    tick();
    checks++;
    if (din_ready !== 1'b0 || ks_req !== 1'b0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL six_wait1: din_ready=%b ks_req=%b dout_valid=%b want 0 0 0", din_ready, ks_req, dout_valid);
    end
    tick();
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL six_wait2: din_ready=%b want 0", din_ready); end
    ks_valid = 1'b1;
    ks_data  = KS2;
    tick();
    ks_valid = 1'b0;
    tick();
    checks++;
    if (dout_data !== (word(4) ^ lane_pat(4'hC)) || dout_last !== 1'b0) begin
      errors++; $display("FAIL six_word4: got %h last=%b want %h last=0", dout_data, dout_last, word(4) ^ lane_pat(4'hC));
    end
    din_data = word(5);
    din_last = 1'b1;
    tick();
    checks++;
    if (dout_data !== (word(5) ^ lane_pat(4'hD)) || dout_last !== 1'b1) begin
      errors++; $display("FAIL six_word5: got %h last=%b want %h last=1", dout_data, dout_last, word(5) ^ lane_pat(4'hD));
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL six_idle: busy=%b want 0", busy); end
  endtask
`endif

  task automatic test_backpressure();
    int x0;
    begin_msg(KS1);
    dout_ready = 1'b0;
    din_valid  = 1'b1;
    din_data   = word(0);
    din_last   = 1'b0;
    x0 = xfer_cnt;
    tick();
    din_data = word(1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_data !== (word(0) ^ lane_pat(4'h0)) || din_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%b data=%h rdy=%b want 1 %h 0", k, dout_valid, dout_data, din_ready, word(0) ^ lane_pat(4'h0));
      end
    end
    dout_ready = 1'b1;
    din_valid  = 1'b0;
    tick();
    checks++;
    if (dout_valid !== 1'b0 || xfer_cnt - x0 !== 1) begin
      errors++; $display("FAIL bp_release: v=%b transfers=%0d want 0 1", dout_valid, xfer_cnt - x0);
    end
    din_valid = 1'b1;
    din_last  = 1'b1;
    tick();
    checks++;
    if (dout_data !== (word(1) ^ lane_pat(4'h1)) || dout_last !== 1'b1) begin
      errors++; $display("FAIL bp_word1: got %h last=%b want %h last=1", dout_data, dout_last, word(1) ^ lane_pat(4'h1));
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    tick();
  endtask

  task automatic test_early_last();
    int c0;
    begin_msg(KS1);
    dout_ready = 1'b1;
    din_valid  = 1'b1;
    din_data   = '0;
    din_last   = 1'b0;
    tick();
    din_last = 1'b1;
    tick();
    checks++;
    if (dout_data !== lane_pat(4'h1) || dout_last !== 1'b1) begin
      errors++; $display("FAIL early_word1: got %h last=%b want %h last=1", dout_data, dout_last, lane_pat(4'h1));
    end
    din_last = 1'b0;
    c0 = ks_req_cnt;
    repeat (4) tick();
    checks++;
    if (ks_req_cnt !== c0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL early_idle: extra_req=%0d busy=%b v=%b want 0 0 0", ks_req_cnt - c0, busy, dout_valid);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (ks_req !== 1'b1 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL early_restart: ks_req=%b dout_valid=%b want 1 0", ks_req, dout_valid);
    end
    tick();
    ks_valid = 1'b1;
    ks_data  = KS2;
    tick();
    ks_valid = 1'b0;
    din_last = 1'b1;
    tick();
    checks++;
    if (dout_data !== lane_pat(4'hC) || dout_last !== 1'b1) begin
      errors++; $display("FAIL early_fresh_lane0: got %h want %h", dout_data, lane_pat(4'hC));
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    begin_msg(KS1);
    dout_ready = 1'b0;
    din_valid  = 1'b1;
    din_data   = word(2);
    tick();
    din_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0 || ks_req !== 1'b0) begin
      errors++; $display("FAIL rstmid: v=%b busy=%b rdy=%b req=%b want 0 0 0 0", dout_valid, busy, din_ready, ks_req);
    end
    tick();
    rst = 1'b0;
    ks_valid = 1'b1;
    ks_data  = KS2;
    tick();
    ks_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || din_ready !== 1'b0 || dout_data !== 128'h0) begin
      errors++; $display("FAIL rstmid_stale_ks: busy=%b rdy=%b data=%h want 0 0 0", busy, din_ready, dout_data);
    end
    dout_ready = 1'b1;
  endtask

`ifdef CHACHA_XOR_PREFETCH_EN
  task automatic test_prefetch();
    logic [127:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ks_valid = 1'b1;
    ks_data  = KS1;
    tick();
    ks_valid = 1'b0;
    checks++;
    if (ks_req !== 1'b1) begin errors++; $display("FAIL pf_second_req: got %b want 1", ks_req); end
    tick();
    ks_valid = 1'b1;
    ks_data  = KS2;
    tick();
    ks_valid   = 1'b0;
    dout_ready = 1'b1;
    din_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din_data = word(i);
      din_last = (i == 5);
      checks++;
      if (din_ready !== 1'b1) begin errors++; $display("FAIL pf_ready%0d: got %b want 1", i, din_ready); end
      tick();
      exp = word(i) ^ ((i < 4) ? lane_pat(4'(i)) : lane_pat(4'(8 + i)));
      checks++;
      if (dout_valid !== 1'b1 || dout_data !== exp) begin
        errors++; $display("FAIL pf_word%0d: v=%b got %h want %h", i, dout_valid, dout_data, exp);
      end
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
`ifndef CHACHA_XOR_PREFETCH_EN
    test_six_words();
`endif
    test_backpressure();
    test_early_last();
    test_reset_mid();
`ifdef CHACHA_XOR_PREFETCH_EN
    test_prefetch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/chacha_stream_xor.md
CHACHA_STREAM_XOR -- requirements
Module: chacha_stream_xor

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have this port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-003 The block SHALL have this port: start  input  1  one-cycle pulse that begins a message; honoured only in IDLE.
REQ-004 The block SHALL have these ports: din_valid  input  1; din_ready  output  1; din_data  input  128; din_last  input  1, which marks the final word of a message.
REQ-005 The block SHALL have these ports: dout_valid  output  1; dout_ready  input  1; dout_data  output  128; dout_last  output  1.
REQ-006 The block SHALL have these ports: ks_req  output  1 (one-cycle keystream block request); ks_valid  input  1; ks_data  input  512 (keystream block).
REQ-007 The block SHALL have this port: busy  output  1, high when state != IDLE or dout_valid=1.

Function
REQ-008 The block SHALL implement the states IDLE, REQ, WAIT_KS and XOR.
REQ-009 In IDLE the block SHALL hold din_ready=0, ks_req=0 and lane=0; start=1 SHALL move the block to REQ.
REQ-010 In REQ the block SHALL drive ks_req=1 for exactly one cycle, then move to WAIT_KS.
REQ-011 In WAIT_KS, on ks_valid=1, the block SHALL capture ks_data into ks_buf, set lane=0 and move to XOR; ks_valid SHALL be ignored in every other state unless CHACHA_XOR_PREFETCH_EN applies.
REQ-012 In XOR the block SHALL drive din_ready = !dout_valid || dout_ready; din_ready SHALL be 0 in all other states.
REQ-013 On a din accept (din_valid && din_ready), the block SHALL register dout_data = din_data XOR ks_buf[lane*128 +: 128] (lane 0 = bits 127:0), set dout_last = din_last and set dout_valid=1 on the next cycle, giving one-cycle latency.
REQ-014 After each accept, lane SHALL increment by one modulo 4.
REQ-015 If an accept with lane=3 and din_last=0 occurs, the block SHALL move to REQ (non-prefetch build).
REQ-016 If an accept with din_last=1 occurs, the block SHALL move to IDLE and discard the remaining ks_buf lanes; the next message SHALL start from a fresh block.
REQ-017 While dout_valid=1 and dout_ready=0, dout_data and dout_last SHALL hold stable; dout_valid SHALL clear on a dout_ready handshake with no new accept in the same cycle.
REQ-018 start asserted outside IDLE SHALL be ignored; start and din_valid in the same IDLE cycle SHALL NOT accept data.
REQ-019 At most one keystream request SHALL be outstanding (non-prefetch build).

Reset
REQ-020 When rst=1, the block SHALL, at the next clk edge, go to IDLE and set lane=0, dout_valid=0, dout_data=0, dout_last=0, ks_req=0 and busy=0, and clear ks_buf and every prefetch buffer.
REQ-021 A reset asserted mid-message SHALL abandon the message; an in-flight ks_valid arriving after reset SHALL be ignored.

Configuration
REQ-022 When the macro CHACHA_XOR_PREFETCH_EN is defined, the block SHALL add a second 512-bit buffer nxt_buf with a nxt_vld flag, and SHALL issue one extra ks_req one cycle after each block is captured into ks_buf.
REQ-023 With CHACHA_XOR_PREFETCH_EN defined, a ks_valid received in XOR SHALL fill nxt_buf and set nxt_vld=1.
REQ-024 With CHACHA_XOR_PREFETCH_EN defined, on a lane-3 accept with din_last=0 the block SHALL copy nxt_buf into ks_buf and stay in XOR with no bubble if nxt_vld=1, and SHALL go to WAIT_KS otherwise.
REQ-025 With CHACHA_XOR_PREFETCH_EN defined, on a din_last accept the block SHALL clear nxt_vld, and any still-pending response SHALL be ignored.
REQ-026 Without CHACHA_XOR_PREFETCH_EN, the block SHALL have no nxt_buf and SHALL behave per REQ-015 and REQ-019.

Verification
REQ-027 The bench SHALL check: rst=1 for 2 cycles mid-XOR -> dout_valid=0, busy=0, din_ready=0, ks_req=0 on the next cycle.
REQ-028 The bench SHALL check: start, then ks_data={128'h3..3,128'h2..2,128'h1..1,128'h0..0}, then 4 words din=0 -> dout equals 0..0, 1..1, 2..2, 3..3 in order; ks_req is high exactly one cycle, the cycle after start.
REQ-029 The bench SHALL check: a 6-word message, non-prefetch build -> a second ks_req follows the 4th accept; din_ready stays 0 until ks_valid; words 5-6 are XORed with lanes 0-1; dout_last=1 on word 6 only.
REQ-030 The bench SHALL check: dout_ready=0 for 3 cycles with dout_valid=1 -> dout_data is stable and din_ready=0; on release, exactly one transfer occurs.
REQ-031 The bench SHALL check: din_last=1 on word 2 -> the block enters IDLE, no further ks_req occurs, and a new start issues a fresh ks_req with lane=0.
REQ-032 The bench SHALL check, with CHACHA_XOR_PREFETCH_EN: a second ks_req follows the first ks_valid by one cycle, and with din_valid held high, words 4 and 5 accept on consecutive cycles.
